apb_reg_ctrl: RTL and testbench
===============================

APB_REG_CTRL -- requirements
Module: apb_reg_ctrl

Interface
REQ-001 SHALL have parameter AMBA_WORD, default 32, meaning APB data width.
REQ-002 SHALL have parameter AMBA_ADDR_WIDTH, default 20, meaning APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning maximum codeword width.
REQ-004 SHALL have parameter CORE_LATENCY, default 2, meaning cycles from core_start until the ECC core outputs are valid.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- PADDR  in  AMBA_ADDR_WIDTH  APB address.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  AMBA_WORD  APB write data.
- PRDATA  out  AMBA_WORD  APB read data.
- PREADY  out  1  APB ready.
- core_ctrl  out  2  operation: 0 encode, 1 decode, 2 full.
- core_data_in  out  DATA_WIDTH  DATA_IN register.
- core_work_mod  out  AMBA_WORD  CODEWORD_WIDTH register.
- core_noise  out  DATA_WIDTH  NOISE register.
- core_start  out  1  one-cycle operation start pulse.
- core_data_out  in  DATA_WIDTH  result from the encoder/decoder datapath.
- core_num_of_errors  in  2  error count from the decoder.
- operation_done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL decode the register map on PADDR[4:2] and ignore the other address bits: 0 CTRL, 1 DATA_IN, 2 CODEWORD_WIDTH, 3 NOISE, 4 DATA_OUT (RO), 5 NUM_OF_ERRORS (RO); 6-7 unmapped.
REQ-007 SHALL accept a write only in the access phase, when PSEL=1, PENABLE=1 and PWRITE=1; PREADY SHALL be constant 1, giving zero wait states.
REQ-008 SHALL load PRDATA with the addressed register, zero-extended, in the setup phase (PSEL=1, PENABLE=0, PWRITE=0), so PRDATA is valid in the access phase; unmapped addresses SHALL read 0.
REQ-009 SHALL ignore writes to the RO registers and to unmapped addresses.
REQ-010 SHALL store only PWDATA[1:0] on a CTRL write; value 3 SHALL be ignored and SHALL not start an operation.
REQ-011 SHALL use FSM states IDLE, RUN and DONE.
REQ-012 In IDLE, a valid CTRL write SHALL latch core_ctrl, pulse core_start on the next cycle and go to RUN.
REQ-013 In RUN, a counter SHALL count CORE_LATENCY cycles; on the last one the FSM SHALL go to DONE.
REQ-014 In DONE, the block SHALL capture core_data_out into DATA_OUT and core_num_of_errors into NUM_OF_ERRORS, pulse operation_done for one cycle, and return to IDLE.
REQ-015 While in RUN or DONE, writes to CTRL, DATA_IN, CODEWORD_WIDTH and NOISE SHALL be ignored, so core inputs stay stable; reads SHALL remain allowed.
REQ-016 A CTRL write on the same cycle as the DONE-to-IDLE transition SHALL be ignored.
REQ-017 When core_ctrl=0 (encode), NUM_OF_ERRORS SHALL be captured as 0.
REQ-018 Only the last captured DATA_OUT and NUM_OF_ERRORS SHALL be readable; they SHALL persist until the next DONE.

Reset
REQ-019 On rst=0, all registers, PRDATA and the counter SHALL go to 0, core_start and operation_done SHALL go to 0, and the FSM SHALL go to IDLE, immediately and independent of clk.
REQ-020 A reset during RUN SHALL abort the operation without pulsing operation_done.

Structure
REQ-021 The register offsets, the core_ctrl opcode enum and the FSM state enum SHALL live in the shared package ecc_pkg.
REQ-022 The APB register file SHALL stay in apb_reg_ctrl; the sequencer FSM and counter SHALL be the single sub-module ecc_seq_fsm.

Verification
REQ-023 The bench SHALL cover: write DATA_IN=0x0000_000B and CODEWORD_WIDTH=0, then read both -> PRDATA returns 0xB and 0x0.
REQ-024 The bench SHALL cover: write CTRL=1 in IDLE -> core_start high on the next cycle, operation_done high exactly CORE_LATENCY+1 cycles after core_start, and DATA_OUT equals core_data_out.
REQ-025 The bench SHALL cover: write DATA_IN=0x5 during RUN -> core_data_in unchanged and a readback still returns the old value.
REQ-026 The bench SHALL cover: write CTRL=3 -> no core_start and FSM stays in IDLE.
REQ-027 The bench SHALL cover: read offset 0x18 -> PRDATA=0; assert rst=0 during RUN -> no operation_done and all registers read 0.
REQ-028 The bench SHALL cover: encode with core_num_of_errors driven to 2 -> NUM_OF_ERRORS reads 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC register controller: register offsets,
// core opcodes and sequencer states.
package ecc_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_DATA_IN  = 3'd1;
    localparam logic [2:0] REG_CW_WIDTH = 3'd2;
    localparam logic [2:0] REG_NOISE    = 3'd3;
    localparam logic [2:0] REG_DATA_OUT = 3'd4;
    localparam logic [2:0] REG_NUM_ERR  = 3'd5;

    typedef enum logic [1:0] {
        OP_ENCODE = 2'd0,
        OP_DECODE = 2'd1,
        OP_FULL   = 2'd2,
        OP_RSVD   = 2'd3
    } core_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ecc_seq_fsm.sv
// Operation sequencer: start pulse, CORE_LATENCY wait, capture/done pulse.
import ecc_pkg::*;

module ecc_seq_fsm #(
    parameter int CORE_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    output logic busy,
    output logic capture,
    output logic core_start,
    output logic operation_done
);

    localparam int CW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(CORE_LATENCY - 1);

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_req) begin
                state_d = ST_RUN;
                start_d = 1'b1;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign capture        = (state_q == ST_DONE);
    assign core_start     = start_q;
    assign operation_done = done_q;

endmodule

// File: rtl/apb_reg_ctrl.sv
// APB slave register file fronting an ECC encoder/decoder core; the
// sequencing of each operation lives in ecc_seq_fsm.
import ecc_pkg::*;

module apb_reg_ctrl #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int CORE_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic [1:0]                 core_ctrl,
    output logic [DATA_WIDTH-1:0]      core_data_in,
    output logic [AMBA_WORD-1:0]       core_work_mod,
    output logic [DATA_WIDTH-1:0]      core_noise,
    output logic                       core_start,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_of_errors,
    output logic                       operation_done
);

    logic [2:0] reg_idx;
    logic       wr_en, rd_setup, busy, capture, start_req;
    logic       unused_paddr;

    logic [1:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [AMBA_WORD-1:0]  cw_q, cw_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            nerr_q, nerr_d;
    logic [AMBA_WORD-1:0]  prdata_q, prdata_d, rd_val;

    assign reg_idx      = PADDR[4:2];
    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign rd_setup     = PSEL & ~PENABLE & ~PWRITE;
    // Reserved opcode must neither latch nor launch an operation.
    assign start_req    = wr_en & ~busy & (reg_idx == REG_CTRL) & (PWDATA[1:0] != OP_RSVD);

    ecc_seq_fsm #(.CORE_LATENCY(CORE_LATENCY)) u_seq (
        .clk            (clk),
        .rst            (rst),
        .start_req      (start_req),
        .busy           (busy),
        .capture        (capture),
        .core_start     (core_start),
        .operation_done (operation_done)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        cw_d       = cw_q;
        noise_d    = noise_q;
        data_out_d = data_out_q;
        nerr_d     = nerr_q;
        if (wr_en && !busy) begin
            case (reg_idx)
                REG_CTRL:     if (start_req) ctrl_d = PWDATA[1:0];
                REG_DATA_IN:  data_in_d = PWDATA[DATA_WIDTH-1:0];
                REG_CW_WIDTH: cw_d      = PWDATA;
                REG_NOISE:    noise_d   = PWDATA[DATA_WIDTH-1:0];
                default: ;
            endcase
        end
        if (capture) begin
            data_out_d = core_data_out;
            nerr_d     = (ctrl_q == OP_ENCODE) ? 2'd0 : core_num_of_errors;
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_CTRL:     rd_val[1:0]            = ctrl_q;
            REG_DATA_IN:  rd_val[DATA_WIDTH-1:0] = data_in_q;
            REG_CW_WIDTH: rd_val                 = cw_q;
            REG_NOISE:    rd_val[DATA_WIDTH-1:0] = noise_q;
            REG_DATA_OUT: rd_val[DATA_WIDTH-1:0] = data_out_q;
            REG_NUM_ERR:  rd_val[1:0]            = nerr_q;
            default: ;
        endcase
        prdata_d = rd_setup ? rd_val : prdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cw_q       <= '0;
            noise_q    <= '0;
            data_out_q <= '0;
            nerr_q     <= '0;
            prdata_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            cw_q       <= cw_d;
            noise_q    <= noise_d;
            data_out_q <= data_out_d;
            nerr_q     <= nerr_d;
            prdata_q   <= prdata_d;
        end
    end

    assign PRDATA        = prdata_q;
    assign PREADY        = 1'b1;
    assign core_ctrl     = ctrl_q;
    assign core_data_in  = data_in_q;
    assign core_work_mod = cw_q;
    assign core_noise    = noise_q;

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Bench for apb_reg_ctrl: directed vector table, corner sequences and
// random APB traffic against an edge-indexed register/operation model.
module tb_apb_reg_ctrl;
    localparam int AW = 32, ADW = 20, DW = 32, LAT = 2;

    logic           clk = 1'b0, rst = 1'b0;
    logic [ADW-1:0] PADDR = '0;
    logic           PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [AW-1:0]  PWDATA = '0, PRDATA;
    logic           PREADY, core_start, operation_done;
    logic [1:0]     core_ctrl, core_num_of_errors = '0;
    logic [DW-1:0]  core_data_in, core_noise, core_data_out = '0;
    logic [AW-1:0]  core_work_mod;

    apb_reg_ctrl #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .CORE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .core_ctrl(core_ctrl),
        .core_data_in(core_data_in), .core_work_mod(core_work_mod), .core_noise(core_noise),
        .core_start(core_start), .core_data_out(core_data_out),
        .core_num_of_errors(core_num_of_errors), .operation_done(operation_done));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int edge_n = 0, start_cnt = 0, done_cnt = 0, last_start_edge = 0, last_done_edge = 0;

    // Reference model: register contents plus the edge numbers at which
    // the pending operation starts, completes and becomes readable.
    logic [1:0]  m_ctrl, m_nerr, cap_nerr;
    logic [31:0] m_din, m_cw, m_noise, m_dout, cap_dout;
    int          busy_end, cap_edge;
    bit          pend;
    int          start_q[$], done_q[$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_din = 0; m_cw = 0; m_noise = 0; m_dout = 0; m_nerr = 0;
        busy_end = -100; cap_edge = -100; pend = 0;
        start_q.delete(); done_q.delete();
    endtask

    task automatic model_sync(input int e);
        if (pend && e > cap_edge) begin
            m_dout = cap_dout; m_nerr = cap_nerr; pend = 0;
        end
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input int e);
        model_sync(e);
        if (e > busy_end) begin
            case (idx)
                3'd0: if (d[1:0] != 2'd3) begin
                    m_ctrl   = d[1:0];
                    busy_end = e + LAT + 1;
                    cap_edge = busy_end;
                    cap_dout = core_data_out;
                    cap_nerr = (d[1:0] == 2'd0) ? 2'd0 : core_num_of_errors;
                    pend     = 1;
                    start_q.push_back(e);
                    done_q.push_back(e + LAT + 1);
                end
                3'd1: m_din   = d;
                3'd2: m_cw    = d;
                3'd3: m_noise = d;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0: return {30'd0, m_ctrl};
            3'd1: return m_din;
            3'd2: return m_cw;
            3'd3: return m_noise;
            3'd4: return m_dout;
            3'd5: return {30'd0, m_nerr};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++; last_start_edge = edge_n;
            chk("start_edge", edge_n, (start_q.size() > 0) ? start_q.pop_front() : -1);
        end
        if (operation_done) begin
            done_cnt++; last_done_edge = edge_n;
            chk("done_edge", edge_n, (done_q.size() > 0) ? done_q.pop_front() : -1);
        end
    end

    task automatic apb_write(input logic [ADW-1:0] a, input logic [AW-1:0] d);
        @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(negedge clk); PENABLE = 1; model_write(a[4:2], d, edge_n + 1);
        @(negedge clk); PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [ADW-1:0] a, output logic [AW-1:0] d, output int e);
        @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a; e = edge_n + 1;
        @(negedge clk); PENABLE = 1; d = PRDATA;
        @(negedge clk); PSEL = 0; PENABLE = 0;
    endtask

    task automatic read_chk(input string n, input logic [ADW-1:0] a, input logic [AW-1:0] exp);
        logic [AW-1:0] d; int e;
        apb_read(a, d, e);
        chk(n, d, exp);
    endtask

    task automatic check_core();
        chk("core_ctrl", core_ctrl, m_ctrl);
        chk("core_data_in", core_data_in, m_din);
        chk("core_work_mod", core_work_mod, m_cw);
        chk("core_noise", core_noise, m_noise);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 30) begin @(negedge clk); n++; end
        chk("done_seen", done_cnt > prev, 1);
    endtask

    typedef struct { bit wr; logic [ADW-1:0] addr; logic [AW-1:0] data; } vec_t;
    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", edge_n);
        $fatal(1);
    end

    initial begin
        int prev;
        logic [AW-1:0] d;
        int e;
        model_reset();
        #12;
        chk("rst_prdata", PRDATA, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_op_done", operation_done, 0);
        chk("pready", PREADY, 1);
        check_core();
        @(negedge clk); rst = 1;

        tbl = '{'{1'b1, 20'h00004, 32'h0000_000B}, '{1'b1, 20'h00008, 32'h0},
                '{1'b0, 20'h00004, 32'h0000_000B}, '{1'b0, 20'h00008, 32'h0},
                '{1'b1, 20'h0000C, 32'hA5A5_0F0F}, '{1'b0, 20'h0000C, 32'hA5A5_0F0F},
                '{1'b0, 20'h00018, 32'h0},         '{1'b0, 20'h0001C, 32'h0},
                '{1'b1, 20'h00010, 32'hFFFF_FFFF}, '{1'b0, 20'h00010, 32'h0},
                '{1'b1, 20'h00018, 32'h0000_1234}, '{1'b0, 20'h00014, 32'h0},
                '{1'b1, 20'h00024, 32'h0000_0077}, '{1'b0, 20'h00004, 32'h0000_0077},
                '{1'b0, 20'hFFF08, 32'h0},         '{1'b0, 20'h00000, 32'h0}};
        foreach (tbl[i]) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else read_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data);
        end
        check_core();

        // Decode operation: start next cycle, done LAT+1 cycles later, capture.
        core_data_out = 32'hDEAD_BEEF; core_num_of_errors = 2'd1;
        prev = done_cnt;
        apb_write(20'h0, 32'h1);
        chk("start_next_cycle", core_start, 1);
        chk("ctrl_latched", core_ctrl, 1);
        wait_done(prev);
        chk("done_latency", last_done_edge - last_start_edge, LAT + 1);
        read_chk("data_out", 20'h10, 32'hDEAD_BEEF);
        read_chk("num_err_dec", 20'h14, 32'h1);

        // Writes during RUN are dropped.
        apb_write(20'h4, 32'h33);
        prev = done_cnt;
        apb_write(20'h0, 32'h2);
        apb_write(20'h4, 32'h5);
        chk("din_held_run", core_data_in, 32'h33);
        read_chk("din_readback_run", 20'h4, 32'h33);
        wait_done(prev);

        // Reserved opcode: no start, block stays idle.
        prev = start_cnt;
        apb_write(20'h0, 32'h3);
        repeat (5) @(negedge clk);
        chk("ctrl3_no_start", start_cnt, prev);
        chk("ctrl3_ctrl_kept", core_ctrl, 2);
        apb_write(20'h4, 32'h9);
        read_chk("ctrl3_idle_write", 20'h4, 32'h9);

        // Encode forces NUM_OF_ERRORS to 0.
        core_data_out = 32'h0BAD_F00D; core_num_of_errors = 2'd2;
        prev = done_cnt;
        apb_write(20'h0, 32'hFFFF_FFFC);
        wait_done(prev);
        read_chk("num_err_enc", 20'h14, 32'h0);
        read_chk("data_out_enc", 20'h10, 32'h0BAD_F00D);
        read_chk("ctrl_enc", 20'h0, 32'h0);

        // Reset during RUN aborts with no completion pulse.
        prev = done_cnt;
        apb_write(20'h0, 32'h1);
        @(negedge clk); #2 rst = 0;
        #1;
        chk("async_rst_prdata", PRDATA, 0);
        chk("async_rst_din", core_data_in, 0);
        chk("async_rst_ctrl", core_ctrl, 0);
        chk("async_rst_start", core_start, 0);
        model_reset();
        repeat (8) @(negedge clk);
        rst = 1;
        chk("rst_no_done", done_cnt, prev);
        for (int i = 0; i < 6; i++) read_chk($sformatf("rst_reg%0d", i), ADW'(i * 4), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 120; i++) begin
            logic [2:0] idx;
            logic [ADW-1:0] a;
            logic [AW-1:0] wd;
            if (edge_n > busy_end && ($urandom % 3) == 0) begin
                core_data_out = $urandom; core_num_of_errors = 2'($urandom);
            end
            idx = 3'($urandom);
            a   = ADW'({2'($urandom), idx, 2'($urandom)});
            wd  = $urandom;
            if (($urandom % 2) == 0) begin
                apb_write(a, wd);
                check_core();
            end else begin
                apb_read(a, d, e);
                model_sync(e);
                chk($sformatf("rand_rd%0d", idx), d, model_read(idx));
            end
        end
        repeat (LAT + 4) @(negedge clk);
        chk("start_q_empty", start_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
